axi_lite_regbank: RTL and testbench
===================================

Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit slave-register IP.
- Register count, data width and reset value are configurable. Adds byte strobes, SLVERR decode, hardware-side load ports and per-register write pulses.
- Sits behind the AXI interconnect/VIP master and exposes registers to user logic in the PL.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
- NUM_REGS, 8, number of registers (2..256).
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must be >= clog2(NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8).
- RESET_VAL, 0, reset value of every register.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  OKAY/SLVERR
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
- reg_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flat register contents; reg i occupies [i*DW +: DW]
- reg_wr_pulse  out  NUM_REGS  1-cycle pulse when AXI commits to reg i
- hw_wr_en  in  NUM_REGS  hardware load enable per register
- hw_wr_data  in  NUM_REGS*C_S_AXI_DATA_WIDTH  hardware load data, same packing as reg_out

Behaviour:
- One clock (S_AXI_ACLK). Reset S_AXI_ARESETN is asynchronous, active-low.
- Reset values: all registers = RESET_VAL. AWREADY, WREADY, BVALID, ARREADY, RVALID and reg_wr_pulse = 0. BRESP, RRESP and RDATA = 0.
- Register index = ADDR[clog2(NUM_REGS)+lsb-1 : lsb], where lsb = clog2(DW/8). Low address bits are ignored.
- Index >= NUM_REGS, or any nonzero address bits above the index field, is out of range.

Write path:
- AW and W are accepted independently, each into a 1-entry holding buffer.
- AWREADY = AW buffer empty and BVALID=0. WREADY = W buffer empty and BVALID=0.
- When both buffers are full, commit in the next cycle:
  - In range: each byte with WSTRB set is written.
  - reg_wr_pulse[idx]=1 for exactly that cycle, even if WSTRB=0.
  - BVALID=1 with BRESP=OKAY.
  - Out of range: no register changes, no pulse, BRESP=SLVERR.
  - Both buffers are cleared on commit.
- BVALID holds until BREADY; there is one outstanding write.
- Minimum latency from AW+W handshake to BVALID is 1 cycle.

Read path:
- ARREADY = !RVALID.
- On the AR handshake, the next cycle has RVALID=1, RDATA = register value or 0 if out of range, and RRESP = OKAY or SLVERR.
- RDATA and RRESP stay stable while RVALID=1 and RREADY=0. RVALID clears on the RREADY handshake.
- A back-to-back AR is accepted in the cycle after the R handshake.

Hardware load:
- hw_wr_en[i] loads hw_wr_data slice i on the next edge.
- If hw_wr_en[i] and an AXI commit to reg i occur in the same cycle, AXI wins on strobed bytes and hardware wins on unstrobed bytes.

Other rules:
- A read sampled in the same cycle as a write commit to the same register returns the pre-write value.
- Reset asserted mid-transaction aborts it: valids drop immediately and buffered AW/W are discarded.

Optional Feature:
REGBANK_IRQ_EN
- Defined:
  - Adds ports irq_src (in, DW) and irq (out, 1).
  - Reg NUM_REGS-1 becomes a sticky status register: a bit is set in any cycle where its irq_src bit=1.
  - AXI write to the status register is write-1-to-clear per strobed byte. Set beats clear in the same cycle.
  - Reg NUM_REGS-2 is the interrupt enable mask.
  - irq is registered: irq <= |(status & mask). Reset value 0.
  - hw_wr_en is ignored for the status register.
- Undefined: ports irq_src and irq are absent, and every register is plain RW.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> reads return 0x1..0x4, RRESP=OKAY, one reg_wr_pulse per write.
- Write 0xAABBCCDD to reg 0 with WSTRB=0b0101 after reset, RESET_VAL=0 -> read 0x00BB00DD.
- Present W 3 cycles before AW, and hold BREADY=0 for 5 cycles -> commit occurs the cycle after AW; BVALID held, no new AWREADY until the B handshake.
- Write and read address 0x20 with NUM_REGS=8 -> BRESP=SLVERR and RRESP=SLVERR, RDATA=0, registers unchanged.
- Same cycle: hw_wr_en[1] with hw_wr_data=0x11111111 and AXI write 0x22222222 to reg 1 with WSTRB=0b0011 -> reg 1=0x11112222.
- REGBANK_IRQ_EN: mask=0x1, pulse irq_src[0] -> irq=1. Write 0x1 to the status register -> irq=0 two cycles later.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank: byte strobes, SLVERR decode, hardware load ports
// and per-register write pulses. Define REGBANK_IRQ_EN for the sticky status / irq mask pair.
module axi_lite_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = {C_S_AXI_DATA_WIDTH{1'b0}}
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
`ifdef REGBANK_IRQ_EN
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            irq_src,
    output logic                                     irq,
`endif
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [NUM_REGS-1:0]                      reg_wr_pulse,
    input  logic [NUM_REGS-1:0]                      hw_wr_en,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_wr_data
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int NB    = DW / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // An address is valid only if the index is populated and every bit above the index field is zero.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        logic [AW-1:0]  upper;
        logic [IDX_W:0] idx;
        upper = addr >> (IDX_W + LSB);
        idx   = {1'b0, addr[IDX_W+LSB-1:LSB]};
        return (upper == {AW{1'b0}}) && (idx < (IDX_W+1)'(NUM_REGS));
    endfunction

    logic [DW-1:0]       regs_r [NUM_REGS];
    logic [DW-1:0]       reg_next_s [NUM_REGS];
    logic                aw_full_r, w_full_r, bvalid_r, rvalid_r;
    logic                awready_r, wready_r, arready_r;
    logic [AW-1:0]       aw_addr_r;
    logic [DW-1:0]       w_data_r, rdata_r, rd_data_s;
    logic [NB-1:0]       w_strb_r;
    logic [1:0]          bresp_r, rresp_r;
    logic [NUM_REGS-1:0] reg_wr_pulse_r;
    logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s, w_ok_s, r_ok_s, byte_hit_s;
    logic                aw_full_next_s, w_full_next_s, bvalid_next_s, rvalid_next_s;
    logic [IDX_W-1:0]    w_idx_s, r_idx_s;
    logic                unused_s;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs_s  = S_AXI_AWVALID && awready_r;
    assign w_hs_s   = S_AXI_WVALID && wready_r;
    assign ar_hs_s  = S_AXI_ARVALID && arready_r;
    assign commit_s = aw_full_r && w_full_r;
    assign w_idx_s  = aw_addr_r[IDX_W+LSB-1:LSB];
    assign w_ok_s   = addr_ok(aw_addr_r);
    assign r_idx_s  = S_AXI_ARADDR[IDX_W+LSB-1:LSB];
    assign r_ok_s   = addr_ok(S_AXI_ARADDR);

    // Buffer occupancy and response-valid next state.
    always_comb begin
        aw_full_next_s = aw_full_r;
        w_full_next_s  = w_full_r;
        bvalid_next_s  = bvalid_r;
        rvalid_next_s  = rvalid_r;
        if (commit_s) begin
            aw_full_next_s = 1'b0;
            w_full_next_s  = 1'b0;
            bvalid_next_s  = 1'b1;
        end else begin
            aw_full_next_s = aw_full_r || aw_hs_s;
            w_full_next_s  = w_full_r || w_hs_s;
            bvalid_next_s  = bvalid_r && !S_AXI_BREADY;
        end
        if (ar_hs_s) begin
            rvalid_next_s = 1'b1;
        end else begin
            rvalid_next_s = rvalid_r && !S_AXI_RREADY;
        end
    end

    // Read mux over the register array.
    always_comb begin
        rd_data_s = {DW{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = (r_idx_s == IDX_W'(i)) ? regs_r[i] : rd_data_s;
        end
    end

    // Per-byte register update: AXI strobed bytes beat the hardware load port.
    always_comb begin
        byte_hit_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_next_s[i] = regs_r[i];
            for (int b = 0; b < NB; b++) begin
                byte_hit_s = commit_s && w_ok_s && (w_idx_s == IDX_W'(i)) && w_strb_r[b];
                if (byte_hit_s) begin
                    reg_next_s[i][b*8 +: 8] = w_data_r[b*8 +: 8];
                end else if (hw_wr_en[i]) begin
                    reg_next_s[i][b*8 +: 8] = hw_wr_data[i*DW + b*8 +: 8];
                end else begin
                    reg_next_s[i][b*8 +: 8] = regs_r[i][b*8 +: 8];
                end
`ifdef REGBANK_IRQ_EN
                if (i == NUM_REGS - 1) begin
                    reg_next_s[i][b*8 +: 8] = irq_src[b*8 +: 8] |
                        (regs_r[i][b*8 +: 8] & ~(byte_hit_s ? w_data_r[b*8 +: 8] : 8'h00));
                end else begin
                    reg_next_s[i][b*8 +: 8] = reg_next_s[i][b*8 +: 8];
                end
`endif
            end
        end
    end

    // Register array storage.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= reg_next_s[i];
        end
    end

    // Write channel: holding buffers, readies, response and commit pulse.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_r      <= 1'b0;
            w_full_r       <= 1'b0;
            bvalid_r       <= 1'b0;
            awready_r      <= 1'b0;
            wready_r       <= 1'b0;
            aw_addr_r      <= {AW{1'b0}};
            w_data_r       <= {DW{1'b0}};
            w_strb_r       <= {NB{1'b0}};
            bresp_r        <= 2'b00;
            reg_wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            aw_full_r <= aw_full_next_s;
            w_full_r  <= w_full_next_s;
            bvalid_r  <= bvalid_next_s;
            awready_r <= !aw_full_next_s && !bvalid_next_s;
            wready_r  <= !w_full_next_s && !bvalid_next_s;
            if (aw_hs_s) aw_addr_r <= S_AXI_AWADDR;
            if (w_hs_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
            if (commit_s) bresp_r <= w_ok_s ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse_r[i] <= commit_s && w_ok_s && (w_idx_s == IDX_W'(i));
            end
        end
    end

    // Read channel: data is captured at the AR handshake so it sees pre-commit register values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rdata_r   <= {DW{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            rvalid_r  <= rvalid_next_s;
            arready_r <= !rvalid_next_s;
            if (ar_hs_s) begin
                rdata_r <= r_ok_s ? rd_data_s : {DW{1'b0}};
                rresp_r <= r_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

`ifdef REGBANK_IRQ_EN
    logic irq_r;

    // Interrupt output from status (last reg) masked by enable (second-to-last reg).
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(regs_r[NUM_REGS-1] & regs_r[NUM_REGS-2]);
        end
    end
    assign irq = irq_r;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = regs_r[g];
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign reg_wr_pulse  = reg_wr_pulse_r;
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank (default parameters: 8 x 32-bit, RESET_VAL=0).
// A vector table covers plain read/write traffic; hand sequences cover timing corner cases.
module tb_axi_lite_regbank;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out, hw_wr_data;
    logic [7:0]   reg_wr_pulse, hw_wr_en;
`ifdef REGBANK_IRQ_EN
    logic [31:0]  irq_src;
    logic         irq;
`endif

    int tests = 0;
    int fails = 0;
    int pulse_cnt [8];

    always #5 clk = ~clk;

    axi_lite_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef REGBANK_IRQ_EN
        .irq_src(irq_src), .irq(irq),
`endif
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] regv(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic a_ok, w_ok;
        int c;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; resp = 2'b11;
        for (c = 0; c < 40 && (awvalid || wvalid); c++) begin
            @(negedge clk);
            a_ok = awvalid && awready;
            w_ok = wvalid && wready;
            @(posedge clk); #1;
            if (a_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bvalid) begin
                resp = bresp;
                break;
            end
        end
        @(posedge clk); #1;
        bready = 1'b0;
        check("write completes in budget", 64'(c < 40), 64'd1);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ok;
        int c;
        araddr = a; arvalid = 1'b1; rready = 1'b1; d = 32'hxxxxxxxx; resp = 2'b11;
        for (c = 0; c < 40 && arvalid; c++) begin
            @(negedge clk);
            ok = arready;
            @(posedge clk); #1;
            if (ok) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rvalid) begin
                d = rdata;
                resp = rresp;
                break;
            end
        end
        @(posedge clk); #1;
        rready = 1'b0;
        check("read completes in budget", 64'(c < 40), 64'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;

    vec_t        vec [17];
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          exp_pulse [8];

    initial begin
        vec[0]  = '{1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, 32'h0,        2'b00};
        vec[1]  = '{1'b0, 8'h00, 32'h0,        4'b0000, 32'h00BB00DD, 2'b00};
        vec[2]  = '{1'b1, 8'h00, 32'h1,        4'b1111, 32'h0,        2'b00};
        vec[3]  = '{1'b1, 8'h04, 32'h2,        4'b1111, 32'h0,        2'b00};
        vec[4]  = '{1'b1, 8'h08, 32'h3,        4'b1111, 32'h0,        2'b00};
        vec[5]  = '{1'b1, 8'h0C, 32'h4,        4'b1111, 32'h0,        2'b00};
        vec[6]  = '{1'b0, 8'h00, 32'h0,        4'b0000, 32'h1,        2'b00};
        vec[7]  = '{1'b0, 8'h04, 32'h0,        4'b0000, 32'h2,        2'b00};
        vec[8]  = '{1'b0, 8'h08, 32'h0,        4'b0000, 32'h3,        2'b00};
        vec[9]  = '{1'b0, 8'h0C, 32'h0,        4'b0000, 32'h4,        2'b00};
        vec[10] = '{1'b0, 8'h05, 32'h0,        4'b0000, 32'h2,        2'b00};
        vec[11] = '{1'b1, 8'h1C, 32'hFFFFFFFF, 4'b0000, 32'h0,        2'b00};
        vec[12] = '{1'b0, 8'h1C, 32'h0,        4'b0000, 32'h0,        2'b00};
        vec[13] = '{1'b1, 8'h20, 32'hDEADBEEF, 4'b1111, 32'h0,        2'b10};
        vec[14] = '{1'b0, 8'h20, 32'h0,        4'b0000, 32'h0,        2'b10};
        vec[15] = '{1'b0, 8'h80, 32'h0,        4'b0000, 32'h0,        2'b10};
        vec[16] = '{1'b0, 8'h00, 32'h0,        4'b0000, 32'h1,        2'b00};
        exp_pulse = '{2, 1, 1, 1, 0, 0, 0, 1};

        rst_n = 1'b0; awaddr = 8'h00; araddr = 8'h00; awprot = 3'b000; arprot = 3'b000;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; hw_wr_en = 8'h00; hw_wr_data = 256'h0;
`ifdef REGBANK_IRQ_EN
        irq_src = 32'h0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset handshake outs", {awready, wready, arready, bvalid, rvalid, reg_wr_pulse}, 64'h0);
        check("reset resp/rdata", {bresp, rresp, rdata}, 64'h0);
        check("reset reg_out", 64'(|reg_out), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        for (int k = 0; k < 17; k++) begin
            if (vec[k].wr) begin
                axi_write(vec[k].addr, vec[k].data, vec[k].strb, rsp);
                check($sformatf("vec%0d bresp", k), rsp, vec[k].resp);
            end else begin
                axi_read(vec[k].addr, rd, rsp);
                check($sformatf("vec%0d rdata", k), rd, vec[k].exp);
                check($sformatf("vec%0d rresp", k), rsp, vec[k].resp);
            end
        end
        for (int i = 0; i < 8; i++) check($sformatf("pulse count reg%0d", i), pulse_cnt[i], exp_pulse[i]);
        check("reg_out reg0", regv(0), 32'h1);

        // W three cycles ahead of AW, then BREADY held low.
        @(posedge clk); #1 wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); check("early W ready", wready, 1'b1);
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk); check("late AW ready", awready, 1'b1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk); check("no B before commit", bvalid, 1'b0);
        @(negedge clk);
        check("commit bvalid/bresp/pulse", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 8'h04});
        check("commit reg2", regv(2), 32'h55);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("B held, readies low", {bvalid, awready, wready, reg_wr_pulse}, {3'b100, 8'h00});
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk); check("after B handshake", {bvalid, awready, wready}, 3'b011);

        // Hardware load colliding with AXI commit to reg 1.
        @(posedge clk); #1 awaddr = 8'h04; wdata = 32'h22222222; wstrb = 4'b0011;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        hw_wr_en = 8'h02; hw_wr_data[32 +: 32] = 32'h11111111;
        @(posedge clk); #1 hw_wr_en = 8'h00;
        @(negedge clk); check("hw/axi merge reg1", regv(1), 32'h11112222);
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        hw_wr_en = 8'h20; hw_wr_data[160 +: 32] = 32'hCAFEF00D;
        @(posedge clk); #1 hw_wr_en = 8'h00;
        @(negedge clk); check("hw load reg5", regv(5), 32'hCAFEF00D);
        axi_read(8'h14, rd, rsp);
        check("read hw-loaded reg5", {rsp, rd}, {2'b00, 32'hCAFEF00D});

        // Read sampled on the commit edge of a write to the same register, R held off.
        @(posedge clk); #1 awaddr = 8'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        check("RAW old data", {rvalid, rdata}, {1'b1, 32'h4});
        check("RAW reg3 new", {bvalid, regv(3)}, {1'b1, 32'h77});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("R stable while stalled", {rvalid, arready, rresp, rdata}, {2'b10, 2'b00, 32'h4});
        end
        @(posedge clk); #1 rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1 rready = 1'b0; bready = 1'b0;
        @(negedge clk); check("after R/B handshake", {rvalid, arready, bvalid}, 3'b010);
        axi_read(8'h0C, rd, rsp);
        check("reg3 readback", rd, 32'h77);

`ifdef REGBANK_IRQ_EN
        axi_write(8'h18, 32'h1, 4'hF, rsp);
        @(posedge clk); #1 irq_src = 32'h1;
        @(posedge clk); #1 irq_src = 32'h0;
        @(posedge clk);
        @(negedge clk); check("irq set", {irq, regv(7)}, {1'b1, 32'h1});
        axi_write(8'h1C, 32'h1, 4'hF, rsp);
        @(negedge clk); check("irq cleared", {irq, regv(7)}, {1'b0, 32'h0});
`endif

        // Reset with a buffered AW: the AW must be discarded.
        @(posedge clk); #1 awaddr = 8'h18; awvalid = 1'b1;
        @(negedge clk); check("mid AW ready", awready, 1'b1);
        @(posedge clk); #1 awvalid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid reset outs", {awready, wready, arready, bvalid, rvalid, reg_wr_pulse}, 64'h0);
        check("mid reset reg_out", 64'(|reg_out), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); check("post-reset W ready", wready, 1'b1);
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); check("stale AW discarded", {bvalid, awready, regv(6)}, {2'b01, 32'h0});
        @(posedge clk); #1 awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        @(posedge clk);
        @(negedge clk); check("fresh AW commits", {bvalid, bresp, regv(6)}, {3'b100, 32'h99});
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
